pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the payload in bits.
REQ-002 Parameter RESET_VAL, default 0 (DATA_W bits), payload value loaded by reset; the PC stage instance uses 32'h00003000.
REQ-003 Parameter FLUSH_VAL, default 0 (DATA_W bits), payload value loaded by flush.
REQ-004 Parameter SKID, default 1; 1 selects the two-entry skid mode, 0 selects the single-register mode.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear of the stage contents (bubble insertion).
REQ-008 in_valid  input  1  upstream has a payload.
REQ-009 in_ready  output  1  stage accepts a payload this cycle.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 out_valid  output  1  stage presents a payload.
REQ-012 out_ready  input  1  downstream accepts the payload this cycle.
REQ-013 out_data  output  DATA_W  presented payload, driven directly from the main register.
REQ-014 occupancy  output  2  number of held entries (0, 1 or 2).
REQ-015 stall_cnt  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 A transfer occurs on a port in a cycle where both valid and ready are 1 at the rising edge.
REQ-017 Payloads leave in acceptance order; the main register always holds the older entry and the skid register the newer one.
REQ-018 In skid mode, the state machine has the states EMPTY (occupancy 0), ONE (occupancy 1) and FULL (occupancy 2).
REQ-019 In skid mode, the transitions are as follows:
- EMPTY and in_valid: load main, go to ONE.
- ONE, in_valid and out_ready: load main, stay in ONE.
- ONE, in_valid and !out_ready: load skid, go to FULL.
- ONE, !in_valid and out_ready: go to EMPTY.
- FULL and out_ready: main is loaded from skid, go to ONE.
- In all other cases: hold.
REQ-020 In skid mode, in_ready is registered and equals (state != FULL); it has no combinational path from out_ready.
REQ-021 In skid mode, out_valid is 1 in states ONE and FULL.
REQ-022 In single-register mode, the FULL state and the skid register do not exist, and in_ready = !out_valid | out_ready (combinational).
REQ-023 Latency is one cycle from an in_data transfer to out_valid when the stage was empty or draining.
REQ-024 When out_valid=0, out_data holds its last value (RESET_VAL or FLUSH_VAL after reset or flush).
REQ-025 flush has priority over every other event:
- the next state is EMPTY;
- main and skid are loaded with FLUSH_VAL;
- any input offered in the flush cycle is dropped;
- any output transfer in the flush cycle still counts as completed for the downstream stage.
REQ-026 Simultaneous input and output transfers in ONE keep occupancy at 1 with no bubble, giving full throughput.
REQ-027 stall_cnt increments by 1 in each cycle where out_valid=1 and out_ready=0, and holds at 16'hFFFF.
REQ-028 stall_cnt is not cleared by flush.
REQ-029 Behaviour of in_data is don't-care when in_valid=0; stall_cnt and state are unaffected by in_data.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously enter the following state:
- state EMPTY;
- out_valid 0;
- in_ready 1;
- occupancy 0;
- main and skid equal to RESET_VAL;
- stall_cnt 0.
REQ-031 Deassertion of rst_n is synchronised externally; the first transfer is accepted on the first rising edge with rst_n=1.
REQ-032 Reset asserted mid-operation discards both entries and does not hold any partial state.

Structure
REQ-033 Shared package pipe_pkg SHALL hold the state enum typedef (EMPTY, ONE, FULL) and the constant STALL_CNT_W=16.
REQ-034 The saturating performance counter SHALL be a sub-module sat_counter, parametrised by width.
REQ-035 Each former fixed stage register (instruction/PC, operand, control bundles) SHALL be built from one instance per bundle, with RESET_VAL and FLUSH_VAL set per field.

Verification
REQ-036 Reset check: hold rst_n=0 with in_valid=1 and in_data=32'hDEADBEEF, RESET_VAL=32'h00003000 -> out_valid=0, in_ready=1, out_data=32'h00003000, occupancy=0.
REQ-037 Streaming: send values 1..8 with out_ready=1 on every cycle -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready constantly 1, stall_cnt=0.
REQ-038 Backpressure in skid mode:
- Stimulus: send A, B, C back-to-back, with out_ready=0 from the cycle after A arrives.
- Response: occupancy reaches 2, in_ready=0, and C is held upstream.
- Stimulus: release out_ready.
- Response: output is A, B, C in order with no loss.
REQ-039 Flush in state FULL with in_valid=1 and FLUSH_VAL=0 -> the next cycle shows occupancy=0, out_valid=0 and out_data=0, and the offered input is absent from later output.
REQ-040 Stall counter: hold out_valid=1 and out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; a subsequent flush leaves it at 16'hFFFF, and rst_n=0 clears it to 0.
REQ-041 Single-register mode (SKID=0) with out_ready=0 while out_valid=1 -> in_ready=0 in the same cycle; raising out_ready returns in_ready to 1 combinationally, and occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register and its performance counter.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int              SKID      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_t            r_state;
    logic [DATA_W-1:0] r_main;
    logic              w_stallInc;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] r_skid;
            logic              r_inReady;

            // in_ready is kept as a register so it never depends on out_ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state   <= EMPTY;
                    r_main    <= RESET_VAL;
                    r_skid    <= RESET_VAL;
                    r_inReady <= 1'b1;
                end else if (flush) begin
                    r_state   <= EMPTY;
                    r_main    <= FLUSH_VAL;
                    r_skid    <= FLUSH_VAL;
                    r_inReady <= 1'b1;
                end else begin
                    case (r_state)
                        EMPTY: begin
                            if (in_valid) begin
                                r_main  <= in_data;
                                r_state <= ONE;
                            end
                        end
                        ONE: begin
                            if (in_valid && out_ready) begin
                                r_main <= in_data;
                            end else if (in_valid) begin
                                r_skid    <= in_data;
                                r_state   <= FULL;
                                r_inReady <= 1'b0;
                            end else if (out_ready) begin
                                r_state <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (out_ready) begin
                                r_main    <= r_skid;
                                r_state   <= ONE;
                                r_inReady <= 1'b1;
                            end
                        end
                        default: begin
                            r_state   <= EMPTY;
                            r_inReady <= 1'b1;
                        end
                    endcase
                end
            end

            assign in_ready = r_inReady;
        end else begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= EMPTY;
                    r_main  <= RESET_VAL;
                end else if (flush) begin
                    r_state <= EMPTY;
                    r_main  <= FLUSH_VAL;
                end else begin
                    case (r_state)
                        EMPTY: begin
                            if (in_valid) begin
                                r_main  <= in_data;
                                r_state <= ONE;
                            end
                        end
                        default: begin
                            if (in_valid && out_ready) begin
                                r_main <= in_data;
                            end else if (!in_valid && out_ready) begin
                                r_state <= EMPTY;
                            end
                        end
                    endcase
                end
            end

            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign occupancy = (r_state == FULL) ? 2'd2 :
                       (r_state == ONE)  ? 2'd1 : 2'd0;

    assign w_stallInc = out_valid && !out_ready;

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stallInc),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg in skid mode and single-register mode.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst_n;

    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [1:0]  occ;
    logic [15:0] stallCnt;

    logic        sFlush;
    logic        sInValid;
    logic        sInReady;
    logic [31:0] sInData;
    logic        sOutValid;
    logic        sOutReady;
    logic [31:0] sOutData;
    logic [1:0]  sOcc;
    logic [15:0] sStallCnt;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(
        .DATA_W    (32),
        .RESET_VAL (32'h00003000),
        .FLUSH_VAL (32'h00000000),
        .SKID      (1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .occupancy (occ),
        .stall_cnt (stallCnt)
    );

    pipe_skid_reg #(
        .DATA_W    (32),
        .RESET_VAL (32'h00003000),
        .FLUSH_VAL (32'h00000000),
        .SKID      (0)
    ) u_single (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (sFlush),
        .in_valid  (sInValid),
        .in_ready  (sInReady),
        .in_data   (sInData),
        .out_valid (sOutValid),
        .out_ready (sOutReady),
        .out_data  (sOutData),
        .occupancy (sOcc),
        .stall_cnt (sStallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic ordy, input logic fl);
        inValid  = v;
        inData   = d;
        outReady = ordy;
        flush    = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        sFlush    = 1'b0;
        sInValid  = 1'b0;
        sInData   = 32'h0;
        sOutReady = 1'b0;

        // Reset state with a payload offered upstream
        repeat (3) tick();
        checkOutput("rst_out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("rst_in_ready",  {31'b0, inReady},  32'd1);
        checkOutput("rst_out_data",  outData,           32'h00003000);
        checkOutput("rst_occupancy", {30'b0, occ},      32'd0);
        checkOutput("rst_stall_cnt", {16'b0, stallCnt}, 32'd0);

        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming 1..8 at full throughput
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, i, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("stream_valid_%0d", i), {31'b0, outValid}, 32'd1);
            checkOutput($sformatf("stream_data_%0d", i),  outData,           i);
            checkOutput($sformatf("stream_ready_%0d", i), {31'b0, inReady},  32'd1);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_drain_valid", {31'b0, outValid}, 32'd0);
        checkOutput("stream_hold_data",   outData,           32'd8);
        checkOutput("stream_stall_cnt",   {16'b0, stallCnt}, 32'd0);

        // Backpressure: A, B, C with out_ready dropped after A arrives
        applyStimulus(1'b1, 32'h0000000A, 1'b1, 1'b0);
        tick();
        checkOutput("bp_a_data", outData, 32'h0000000A);
        applyStimulus(1'b1, 32'h0000000B, 1'b0, 1'b0);
        tick();
        checkOutput("bp_full_occ",   {30'b0, occ},     32'd2);
        checkOutput("bp_full_ready", {31'b0, inReady}, 32'd0);
        checkOutput("bp_full_data",  outData,          32'h0000000A);
        applyStimulus(1'b1, 32'h0000000C, 1'b0, 1'b0);
        tick();
        checkOutput("bp_hold_occ",   {30'b0, occ},      32'd2);
        checkOutput("bp_hold_ready", {31'b0, inReady},  32'd0);
        checkOutput("bp_hold_data",  outData,           32'h0000000A);
        checkOutput("bp_stall_cnt",  {16'b0, stallCnt}, 32'd2);
        applyStimulus(1'b1, 32'h0000000C, 1'b1, 1'b0);
        tick();
        checkOutput("bp_b_data", outData,      32'h0000000B);
        checkOutput("bp_b_occ",  {30'b0, occ}, 32'd1);
        tick();
        checkOutput("bp_c_data", outData,      32'h0000000C);
        checkOutput("bp_c_occ",  {30'b0, occ}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("bp_empty_valid", {31'b0, outValid}, 32'd0);

        // Flush while FULL with a new payload offered
        applyStimulus(1'b1, 32'h00000011, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00000022, 1'b0, 1'b0);
        tick();
        checkOutput("fl_pre_occ", {30'b0, occ}, 32'd2);
        applyStimulus(1'b1, 32'h00000033, 1'b0, 1'b1);
        tick();
        checkOutput("fl_occ",   {30'b0, occ},      32'd0);
        checkOutput("fl_valid", {31'b0, outValid}, 32'd0);
        checkOutput("fl_data",  outData,           32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("fl_dropped_valid", {31'b0, outValid}, 32'd0);
        applyStimulus(1'b1, 32'h00000044, 1'b1, 1'b0);
        tick();
        checkOutput("fl_after_data", outData,           32'h00000044);
        checkOutput("fl_stall_cnt",  {16'b0, stallCnt}, 32'd4);

        // Stall counter saturation, flush retention, reset clear
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("sat_value", {16'b0, stallCnt}, 32'h0000FFFF);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("sat_after_flush", {16'b0, stallCnt}, 32'h0000FFFF);
        checkOutput("sat_flush_valid", {31'b0, outValid}, 32'd0);
        applyStimulus(1'b1, 32'h00000055, 1'b0, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_stall", {16'b0, stallCnt}, 32'd0);
        checkOutput("rst_async_occ",   {30'b0, occ},      32'd0);
        checkOutput("rst_async_data",  outData,           32'h00003000);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Single-register mode: combinational in_ready
        sInValid  = 1'b1;
        sInData   = 32'h00000055;
        sOutReady = 1'b1;
        tick();
        checkOutput("sr_valid", {31'b0, sOutValid}, 32'd1);
        checkOutput("sr_data",  sOutData,           32'h00000055);
        checkOutput("sr_occ",   {30'b0, sOcc},      32'd1);
        sInData   = 32'h00000066;
        sOutReady = 1'b0;
        #1;
        checkOutput("sr_ready_low", {31'b0, sInReady}, 32'd0);
        tick();
        checkOutput("sr_hold_data", sOutData,      32'h00000055);
        checkOutput("sr_hold_occ",  {30'b0, sOcc}, 32'd1);
        sOutReady = 1'b1;
        #1;
        checkOutput("sr_ready_high", {31'b0, sInReady}, 32'd1);
        tick();
        checkOutput("sr_next_data", sOutData,      32'h00000066);
        checkOutput("sr_next_occ",  {30'b0, sOcc}, 32'd1);
        sInValid = 1'b0;
        tick();
        checkOutput("sr_empty_occ",   {30'b0, sOcc},     32'd0);
        checkOutput("sr_empty_ready", {31'b0, sInReady}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
